// File: rtl/host_read_fifo8_if.sv
// Host read-strobe bus and fabric push port of host_read_fifo8.
interface host_read_fifo8_if #(
  parameter int AW = 4
);
  logic        Rd;
  logic        En;
  logic        Addr;
  logic [15:0] DataRd;
  logic [7:0]  PushData;
  logic        Push;
  logic        Full;
  logic        Empty;
  logic        Overflow;
  logic [AW:0] Count;

  modport master (
    output Rd, En, Addr, PushData, Push,
    input  DataRd, Full, Empty, Overflow, Count
  );

  modport slave (
    input  Rd, En, Addr, PushData, Push,
    output DataRd, Full, Empty, Overflow, Count
  );
endinterface

// File: rtl/host_read_fifo8.sv
// Byte FIFO filled by fabric logic on Clk and drained by the asynchronous host read strobe.
// A data-register read pops on the rising end of Rd; a status read clears the sticky overflow.
module host_read_fifo8 #(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             Clk,
  input  logic             Reset,
  host_read_fifo8_if.slave bus
);

  typedef enum logic {
    ST_IDLE,
    ST_ACTIVE
  } state_e;

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          ovf_q, ovf_d;
  state_e        state_q, state_d;
  logic          sel_data_q, sel_data_d;
  logic          sel_stat_q, sel_stat_d;
  logic          rd_s1_q, rd_s2_q, rd_s3_q;

  logic          rd_fall, rd_rise;
  logic          commit, pop, push_ok;
  logic          full, empty;
  logic [7:0]    head, count8;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      rd_s1_q <= 1'b1;
      rd_s2_q <= 1'b1;
      rd_s3_q <= 1'b1;
    end else begin
      rd_s1_q <= bus.Rd;
      rd_s2_q <= rd_s1_q;
      rd_s3_q <= rd_s2_q;
    end
  end

  assign rd_fall = rd_s3_q & ~rd_s2_q;
  assign rd_rise = ~rd_s3_q & rd_s2_q;

  // NOTE: every variable gets a default first so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    sel_data_d = sel_data_q;
    sel_stat_d = sel_stat_q;
    commit     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (rd_fall) begin
          sel_data_d = bus.En & ~bus.Addr;
          sel_stat_d = bus.En & bus.Addr;
          state_d    = ST_ACTIVE;
        end
      end
      ST_ACTIVE: begin
        if (rd_rise) begin
          commit     = 1'b1;
          sel_data_d = 1'b0;
          sel_stat_d = 1'b0;
          state_d    = ST_IDLE;
        end
      end
    endcase
  end

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign pop     = commit & sel_data_q & ~empty;
  assign push_ok = bus.Push & (~full | pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)     rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push_ok, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    // A dropped push overrides a same-cycle status-read clear.
    if (commit & sel_stat_q)     ovf_d = 1'b0;
    if (bus.Push & ~push_ok)     ovf_d = 1'b1;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
      state_q    <= ST_IDLE;
      sel_data_q <= 1'b0;
      sel_stat_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
      state_q    <= state_d;
      sel_data_q <= sel_data_d;
      sel_stat_q <= sel_stat_d;
    end
  end

  // NOTE: storage has no reset; Empty masks stale contents on the data port.
  always_ff @(posedge Clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= bus.PushData;
  end

  assign head   = empty ? 8'h00 : mem_q[rd_ptr_q];
  assign count8 = 8'(count_q);

  assign bus.DataRd   = bus.Addr ? {ovf_q, full, empty, 5'b0, count8} : {8'h00, head};
  assign bus.Full     = full;
  assign bus.Empty    = empty;
  assign bus.Overflow = ovf_q;
  assign bus.Count    = count_q;

endmodule

// File: tb/tb_host_read_fifo8.sv
// Directed plus randomized bench for host_read_fifo8 against a queue-based reference model.
module tb_host_read_fifo8;

  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic Clk = 1'b0;
  logic Reset;

  host_read_fifo8_if #(.AW(AW)) bus ();

  host_read_fifo8 #(.DEPTH(DEPTH)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 Clk = ~Clk;

  int total = 0;
  int bad   = 0;

  byte unsigned model_q[$];
  bit           model_ovf;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  function automatic logic [15:0] exp_status();
    int n;
    n = model_q.size();
    return {model_ovf, (n == DEPTH), (n == 0), 5'b0, 8'(n)};
  endfunction

  function automatic logic [15:0] exp_head();
    if (model_q.size() == 0) return 16'h0000;
    return {8'h00, model_q[0]};
  endfunction

  function automatic void model_push(input byte unsigned d);
    if (model_q.size() < DEPTH) model_q.push_back(d);
    else model_ovf = 1'b1;
  endfunction

  task automatic check_state(input string tag);
    check({tag, "/count"}, 32'(bus.Count), 32'(model_q.size()));
    check({tag, "/empty"}, 32'(bus.Empty), 32'(model_q.size() == 0));
    check({tag, "/full"},  32'(bus.Full),  32'(model_q.size() == DEPTH));
    check({tag, "/ovf"},   32'(bus.Overflow), 32'(model_ovf));
  endtask

  task automatic push_cycle(input bit en, input byte unsigned d);
    bus.Push     = en;
    bus.PushData = d;
    tick();
    bus.Push = 1'b0;
    if (en) model_push(d);
  endtask

  // One host strobe; optionally holds Push on the exact cycle the read commits.
  task automatic host_read(input bit en, input bit addr, input bit push_at_commit,
                           input byte unsigned pd, input string tag);
    logic [15:0] exp_word;
    bus.En   = en;
    bus.Addr = addr;
    repeat (3) tick();
    exp_word = addr ? exp_status() : exp_head();
    bus.Rd = 1'b0;
    tick();
    tick();
    check({tag, "/rd_early"}, 32'(bus.DataRd), 32'(exp_word));
    tick();
    tick();
    check({tag, "/rd_late"}, 32'(bus.DataRd), 32'(exp_word));
    bus.Rd = 1'b1;
    tick();
    tick();
    check({tag, "/precommit"}, 32'(bus.Count), 32'(model_q.size()));
    if (push_at_commit) begin
      bus.Push     = 1'b1;
      bus.PushData = pd;
    end
    tick();
    bus.Push = 1'b0;
    if (en && !addr && model_q.size() > 0) void'(model_q.pop_front());
    if (en && addr) model_ovf = 1'b0;
    if (push_at_commit) model_push(pd);
    check_state({tag, "/commit"});
    bus.En = 1'b0;
    tick();
  endtask

  initial begin
    bus.Rd       = 1'b1;
    bus.En       = 1'b0;
    bus.Addr     = 1'b0;
    bus.Push     = 1'b0;
    bus.PushData = 8'h00;
    model_ovf    = 1'b0;

    // Reset
    Reset = 1'b1;
    repeat (2) tick();
    Reset = 1'b0;
    check_state("reset");
    bus.Addr = 1'b1;
    #1;
    check("reset/status", 32'(bus.DataRd), 32'h2000);
    bus.Addr = 1'b0;
    #1;
    check("reset/data", 32'(bus.DataRd), 32'h0000);

    // Push and drain
    push_cycle(1'b1, 8'hA5);
    check("pd/head_after_push", 32'(bus.DataRd), 32'h00A5);
    push_cycle(1'b1, 8'h3C);
    check_state("pd/pushed");
    host_read(1'b1, 1'b0, 1'b0, 8'h00, "pd/read1");
    host_read(1'b1, 1'b0, 1'b0, 8'h00, "pd/read2");

    // Fill, overflow, drain in order, wrap
    for (int i = 0; i < DEPTH; i++) push_cycle(1'b1, 8'(i));
    check_state("fill/full");
    push_cycle(1'b1, 8'hFF);
    check_state("fill/overflow");
    for (int i = 0; i < DEPTH; i++) host_read(1'b1, 1'b0, 1'b0, 8'h00, "fill/drain");
    for (int i = 0; i < 3; i++) push_cycle(1'b1, 8'(8'hC0 + i));
    for (int i = 0; i < 3; i++) host_read(1'b1, 1'b0, 1'b0, 8'h00, "wrap/drain");

    // Status read clears overflow, data untouched
    push_cycle(1'b1, 8'h11);
    push_cycle(1'b1, 8'h22);
    host_read(1'b1, 1'b1, 1'b0, 8'h00, "stat/clear");
    host_read(1'b1, 1'b0, 1'b0, 8'h00, "stat/data1");
    host_read(1'b1, 1'b0, 1'b0, 8'h00, "stat/data2");

    // Push and pop together while full; then overflow set racing a status clear
    while (model_q.size() < DEPTH) push_cycle(1'b1, 8'($urandom_range(0, 255)));
    host_read(1'b1, 1'b0, 1'b1, 8'h77, "full/push_pop");
    host_read(1'b1, 1'b1, 1'b1, 8'h88, "full/set_wins");
    host_read(1'b1, 1'b1, 1'b0, 8'h00, "full/clear");
    while (model_q.size() > 0) host_read(1'b1, 1'b0, 1'b0, 8'h00, "full/drain");

    // Empty read, then push and pop together while empty
    host_read(1'b1, 1'b0, 1'b0, 8'h00, "empty/read");
    host_read(1'b1, 1'b0, 1'b1, 8'h5A, "empty/push_pop");
    host_read(1'b1, 1'b0, 1'b0, 8'h00, "empty/drain");

    // Reset while Rd is low with two bytes queued
    push_cycle(1'b1, 8'hA1);
    push_cycle(1'b1, 8'hB2);
    bus.En   = 1'b1;
    bus.Addr = 1'b0;
    repeat (3) tick();
    bus.Rd = 1'b0;
    repeat (5) tick();
    Reset = 1'b1;
    repeat (2) tick();
    Reset = 1'b0;
    model_q.delete();
    model_ovf = 1'b0;
    tick();
    bus.Rd = 1'b1;
    repeat (6) tick();
    bus.En = 1'b0;
    check_state("midreset/after");
    push_cycle(1'b1, 8'h3E);
    host_read(1'b1, 1'b0, 1'b0, 8'h00, "midreset/resume");

    // Randomized mix of bursts and reads
    for (int it = 0; it < 40; it++) begin
      case ($urandom_range(0, 3))
        0: begin
          for (int c = 0; c < int'($urandom_range(1, 8)); c++)
            push_cycle(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
          check_state("rand/burst");
        end
        1: host_read(1'b1, 1'b0, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), "rand/data");
        2: host_read(1'b1, 1'b1, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), "rand/stat");
        default: host_read(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                           8'($urandom_range(0, 255)), "rand/desel");
      endcase
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
